// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW-hazard, redirect and memory-wait sequencing for the 5-stage RV32I pipeline.
// Optional feature macro HAZARD_FORWARD_EN: forwarding network present, so only load-use stalls.
module hazard_ctrl #(
    parameter int unsigned WAIT_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_id_instruction,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_memread,
    input  logic             id_ex_regwrite,
    input  logic [4:0]       ex_mem_rd,
    input  logic             ex_mem_regwrite,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic [1:0]       ctrl_state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FLUSH = 2'd3
    } ctrl_class_e;

    localparam logic [15:0] TIMEOUT_M1 = 16'(WAIT_TIMEOUT - 32'd1);

    // A used, non-x0 source matching a register about to be written by an older instruction.
    function automatic logic src_hazard(input logic [4:0] src, input logic used,
                                        input logic [4:0] rd, input logic regwrite);
        return used && regwrite && (src != 5'd0) && (src == rd);
    endfunction

    logic [4:0]       opc_s;
    logic [4:0]       rs1_s;
    logic [4:0]       rs2_s;
    logic             rs1_used_s;
    logic             rs2_used_s;
    logic             haz_ex_s;
    logic             stall_s;
    logic             unused_s;
    ctrl_class_e      ctrl_state_d, ctrl_state_q;
    logic [15:0]      wait_run_d, wait_run_q;
    logic             mem_timeout_d, mem_timeout_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

    assign opc_s = if_id_instruction[6:2];
    assign rs1_s = if_id_instruction[19:15];
    assign rs2_s = if_id_instruction[24:20];

    // Which register fields the ID instruction actually reads, by opcode class.
    always_comb begin
        rs1_used_s = 1'b0;
        rs2_used_s = 1'b0;
        case (opc_s)
            5'b01100, 5'b01000, 5'b11000: begin
                rs1_used_s = 1'b1;
                rs2_used_s = 1'b1;
            end
            5'b00100, 5'b00000, 5'b11001: begin
                rs1_used_s = 1'b1;
                rs2_used_s = 1'b0;
            end
            default: begin
                rs1_used_s = 1'b0;
                rs2_used_s = 1'b0;
            end
        endcase
    end

    assign haz_ex_s = src_hazard(rs1_s, rs1_used_s, id_ex_rd, id_ex_regwrite) ||
                      src_hazard(rs2_s, rs2_used_s, id_ex_rd, id_ex_regwrite);

`ifdef HAZARD_FORWARD_EN
    assign stall_s  = haz_ex_s && id_ex_memread;
    assign unused_s = ^{if_id_instruction[31:25], if_id_instruction[14:7],
                        if_id_instruction[1:0], ex_mem_rd, ex_mem_regwrite};
`else
    logic haz_mem_s;
    assign haz_mem_s = src_hazard(rs1_s, rs1_used_s, ex_mem_rd, ex_mem_regwrite) ||
                       src_hazard(rs2_s, rs2_used_s, ex_mem_rd, ex_mem_regwrite);
    // Without forwarding any in-flight producer must retire first; id_ex_memread is irrelevant.
    assign stall_s  = haz_ex_s || haz_mem_s;
    assign unused_s = ^{if_id_instruction[31:25], if_id_instruction[14:7],
                        if_id_instruction[1:0], id_ex_memread};
`endif

    // Per-cycle classification and pipeline register controls, in priority order.
    always_comb begin
        ctrl_state_d = ST_RUN;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (dmem_req && !dmem_ready) begin
            // A pending redirect stays latched in the frozen EX stage and wins once memory is ready.
            ctrl_state_d = ST_WAIT;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
        end else if (ex_branch_taken) begin
            ctrl_state_d = ST_FLUSH;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (stall_s) begin
            ctrl_state_d = ST_STALL;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
        end else begin
            ctrl_state_d = ST_RUN;
        end
    end

    // Watchdog run length and saturating statistics.
    always_comb begin
        wait_run_d    = 16'd0;
        mem_timeout_d = mem_timeout_q;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        if (ctrl_state_d == ST_WAIT) begin
            wait_run_d    = (wait_run_q == 16'hFFFF) ? wait_run_q : wait_run_q + 16'd1;
            mem_timeout_d = mem_timeout_q || (wait_run_q >= TIMEOUT_M1);
        end else begin
            wait_run_d = 16'd0;
        end
        if (((ctrl_state_d == ST_STALL) || (ctrl_state_d == ST_WAIT)) &&
            (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if ((ctrl_state_d == ST_FLUSH) && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_state_q  <= ST_RUN;
            wait_run_q    <= 16'd0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= {CNT_W{1'b0}};
            flush_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            ctrl_state_q  <= ctrl_state_d;
            wait_run_q    <= wait_run_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign ctrl_state  = ctrl_state_q;
    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule
